// File: rtl/exc_ctrl_pkg.sv
// Shared types for the jpu exception sequencer: exception flags, ExcCodes, FSM states,
// Status/Cause field positions and the exception priority encoder.
`ifndef TIMER_PERIOD
`define TIMER_PERIOD 16'd100
`endif

package exc_ctrl_pkg;

    typedef enum logic [4:0] {
        EXC_INT  = 5'd0,
        EXC_ADEL = 5'd4,
        EXC_ADES = 5'd5,
        EXC_IBE  = 5'd6,
        EXC_DBE  = 5'd7,
        EXC_SYS  = 5'd8,
        EXC_BP   = 5'd9,
        EXC_RI   = 5'd10,
        EXC_CPU  = 5'd11,
        EXC_OV   = 5'd12,
        EXC_TR   = 5'd13,
        EXC_FPE  = 5'd15
    } exc_code_e;

    // Bit 10 (adel) down to bit 0 (fpe) of the commit-stage exceptions_s word.
    typedef struct packed {
        logic adel;
        logic ades;
        logic ibe;
        logic dbe;
        logic sys;
        logic bp;
        logic ri;
        logic cpu;
        logic ov;
        logic tr;
        logic fpe;
    } exc_flags_s;

    localparam logic [1:0] S_RUN    = 2'd0;
    localparam logic [1:0] S_FLUSH  = 2'd1;
    localparam logic [1:0] S_VECTOR = 2'd2;

    localparam int ST_IE         = 0;
    localparam int ST_EXL        = 1;
    localparam int ST_IM_LO      = 8;
    localparam int CAUSE_CODE_LO = 2;
    localparam int CAUSE_IP_LO   = 8;

    // Synchronous exceptions ordered by pipeline stage of origin; AdES/DBE come last.
    function automatic exc_code_e exc_prio(input exc_flags_s f);
        if (f.adel)      return EXC_ADEL;
        else if (f.ibe)  return EXC_IBE;
        else if (f.ri)   return EXC_RI;
        else if (f.cpu)  return EXC_CPU;
        else if (f.sys)  return EXC_SYS;
        else if (f.bp)   return EXC_BP;
        else if (f.ov)   return EXC_OV;
        else if (f.tr)   return EXC_TR;
        else if (f.fpe)  return EXC_FPE;
        else if (f.ades) return EXC_ADES;
        else if (f.dbe)  return EXC_DBE;
        else             return EXC_INT;
    endfunction

endpackage

// File: rtl/jpu_timer.sv
// Interval timer: free-running down-counter that reloads at zero and raises a sticky pending bit.
// Pending appears one cycle after the counter reaches zero; expiry beats a same-cycle ack.
module jpu_timer #(
    parameter logic [15:0] PERIOD = 16'd100
) (
    input  logic clk,
    input  logic rst,
    input  logic ack,
    output logic pending
);

    logic [15:0] count_q, count_d;
    logic        pending_q, pending_d;
    logic        expire;

    always_comb begin
        expire    = (count_q == 16'd0);
        count_d   = expire ? (PERIOD - 16'd1) : (count_q - 16'd1);
        pending_d = expire | (pending_q & ~ack);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q   <= PERIOD - 16'd1;
            pending_q <= 1'b0;
        end else begin
            count_q   <= count_d;
            pending_q <= pending_d;
        end
    end

    assign pending = pending_q;

endmodule

// File: rtl/exc_ctrl.sv
// Exception/interrupt sequencer: latches EPC/Cause/BadVAddr, then flush -> redirect (2 cycles
// from event to redirect). Commit-stage inputs are ignored while a flush/redirect is in progress.
module exc_ctrl
    import exc_ctrl_pkg::*;
#(
    parameter logic [31:0] VECTOR_ADDR  = 32'h0000_0080,
    parameter logic [15:0] TIMER_PERIOD = `TIMER_PERIOD,
    parameter int          NUM_IRQ      = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               exc_valid,
    input  logic [10:0]        exc,
    input  logic [31:0]        exc_pc,
    input  logic [31:0]        exc_badaddr,
    input  logic               eret,
    input  logic [NUM_IRQ-1:0] irq,
    input  logic               sr_we,
    input  logic [31:0]        sr_wdata,
    input  logic               timer_ack,
    output logic               flush,
    output logic               stall,
    output logic               redirect,
    output logic [31:0]        redirect_pc,
    output logic [31:0]        epc,
    output logic [31:0]        cause,
    output logic [31:0]        badvaddr,
    output logic [31:0]        status
);

    localparam int IPW = NUM_IRQ + 1;

    logic [1:0]     state_q, state_d;
    logic [31:0]    epc_q, epc_d;
    logic [4:0]     code_q, code_d;
    logic [31:0]    badvaddr_q, badvaddr_d;
    logic           ie_q, ie_d;
    logic           exl_q, exl_d;
    logic [IPW-1:0] im_q, im_d;
    logic [31:0]    target_q, target_d;
    logic           flush_q, flush_d;
    logic           stall_q, stall_d;
    logic           redirect_q, redirect_d;
    logic [31:0]    redirect_pc_q, redirect_pc_d;

    exc_flags_s     exc_f;
    exc_code_e      code_sel;
    logic           timer_pend;
    logic [IPW-1:0] ip;
    logic           any_flag;
    logic           int_pend;
    logic           in_run;
    logic           take_evt;
    logic           take_eret;
    logic           unused_sr;

    jpu_timer #(
        .PERIOD (TIMER_PERIOD)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .ack     (timer_ack),
        .pending (timer_pend)
    );

    assign exc_f     = exc_flags_s'(exc);
    assign code_sel  = exc_prio(exc_f);
    assign ip        = {irq, timer_pend};
    assign any_flag  = |exc;
    assign int_pend  = (|(ip & im_q)) & ie_q & ~exl_q;
    assign in_run    = (state_q == S_RUN);
    assign take_evt  = in_run & exc_valid & (any_flag | int_pend);
    assign take_eret = in_run & exc_valid & eret & ~any_flag & ~take_evt;
    assign unused_sr = ^{sr_wdata[31:ST_IM_LO+IPW], sr_wdata[ST_IM_LO-1:ST_EXL+1]};

    always_comb begin
        state_d    = state_q;
        epc_d      = epc_q;
        code_d     = code_q;
        badvaddr_d = badvaddr_q;
        ie_d       = ie_q;
        exl_d      = exl_q;
        im_d       = im_q;
        target_d   = target_q;

        if (sr_we) begin
            ie_d  = sr_wdata[ST_IE];
            exl_d = sr_wdata[ST_EXL];
            im_d  = sr_wdata[ST_IM_LO +: IPW];
        end

        unique case (state_q)
            S_RUN: begin
                if (take_evt) begin
                    // A nested exception keeps the original return address.
                    if (!exl_q) begin
                        epc_d = exc_pc;
                    end
                    code_d = code_sel;
                    if (code_sel == EXC_ADEL || code_sel == EXC_ADES) begin
                        badvaddr_d = exc_badaddr;
                    end
                    exl_d    = 1'b1;
                    target_d = VECTOR_ADDR;
                    state_d  = S_FLUSH;
                end else if (take_eret) begin
                    exl_d    = 1'b0;
                    target_d = epc_q;
                    state_d  = S_FLUSH;
                end
            end
            S_FLUSH:  state_d = S_VECTOR;
            default:  state_d = S_RUN;
        endcase

        flush_d       = (state_d == S_FLUSH);
        stall_d       = (state_d != S_RUN);
        redirect_d    = (state_d == S_VECTOR);
        redirect_pc_d = (state_d == S_VECTOR) ? target_q : 32'd0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_RUN;
            epc_q         <= 32'd0;
            code_q        <= 5'd0;
            badvaddr_q    <= 32'd0;
            ie_q          <= 1'b0;
            exl_q         <= 1'b0;
            im_q          <= '0;
            target_q      <= 32'd0;
            flush_q       <= 1'b0;
            stall_q       <= 1'b0;
            redirect_q    <= 1'b0;
            redirect_pc_q <= 32'd0;
        end else begin
            state_q       <= state_d;
            epc_q         <= epc_d;
            code_q        <= code_d;
            badvaddr_q    <= badvaddr_d;
            ie_q          <= ie_d;
            exl_q         <= exl_d;
            im_q          <= im_d;
            target_q      <= target_d;
            flush_q       <= flush_d;
            stall_q       <= stall_d;
            redirect_q    <= redirect_d;
            redirect_pc_q <= redirect_pc_d;
        end
    end

    // IP is live (pending timer plus level irq lines), so it is not part of the latched state.
    always_comb begin
        cause = 32'd0;
        cause[CAUSE_CODE_LO +: 5] = code_q;
        cause[CAUSE_IP_LO +: IPW] = ip;

        status = 32'd0;
        status[ST_IE]            = ie_q;
        status[ST_EXL]           = exl_q;
        status[ST_IM_LO +: IPW]  = im_q;
    end

    assign flush       = flush_q;
    assign stall       = stall_q;
    assign redirect    = redirect_q;
    assign redirect_pc = redirect_pc_q;
    assign epc         = epc_q;
    assign badvaddr    = badvaddr_q;

endmodule

// File: tb/tb_exc_ctrl.sv
// Directed bench for exc_ctrl: reset, exception entry, priority, ERET, timer interrupt,
// nested exceptions and reset during a flush.
module tb_exc_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        exc_valid;
    logic [10:0] exc;
    logic [31:0] exc_pc;
    logic [31:0] exc_badaddr;
    logic        eret;
    logic [3:0]  irq;
    logic        sr_we;
    logic [31:0] sr_wdata;
    logic        timer_ack;
    logic        flush;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] epc;
    logic [31:0] cause;
    logic [31:0] badvaddr;
    logic [31:0] status;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    localparam logic [10:0] F_ADEL = 11'b100_0000_0000;
    localparam logic [10:0] F_SYS  = 11'b000_0100_0000;
    localparam logic [10:0] F_OV   = 11'b000_0000_0100;

    exc_ctrl #(
        .VECTOR_ADDR  (32'h0000_0080),
        .TIMER_PERIOD (16'd100),
        .NUM_IRQ      (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .exc_valid   (exc_valid),
        .exc         (exc),
        .exc_pc      (exc_pc),
        .exc_badaddr (exc_badaddr),
        .eret        (eret),
        .irq         (irq),
        .sr_we       (sr_we),
        .sr_wdata    (sr_wdata),
        .timer_ack   (timer_ack),
        .flush       (flush),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .epc         (epc),
        .cause       (cause),
        .badvaddr    (badvaddr),
        .status      (status)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle_inputs();
        exc_valid   = 1'b0;
        exc         = 11'd0;
        exc_pc      = 32'd0;
        exc_badaddr = 32'd0;
        eret        = 1'b0;
        sr_we       = 1'b0;
        sr_wdata    = 32'd0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        checks++;
        if ({flush, stall, redirect} !== 3'b000) begin
            errors++; $display("FAIL reset_ctl got %b exp 000", {flush, stall, redirect});
        end
        checks++;
        if (redirect_pc !== 32'd0 || epc !== 32'd0 || badvaddr !== 32'd0) begin
            errors++; $display("FAIL reset_regs got rpc=%h epc=%h bva=%h exp 0", redirect_pc, epc, badvaddr);
        end
        checks++;
        if (status !== 32'd0 || cause !== 32'd0) begin
            errors++; $display("FAIL reset_sr got status=%h cause=%h exp 0", status, cause);
        end
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (redirect !== 1'b0 || stall !== 1'b0) begin
                errors++; $display("FAIL reset_idle got redirect=%b stall=%b exp 0", redirect, stall);
            end
        end
    endtask

    task automatic test_ov();
        exc_valid = 1'b1; exc = F_OV; exc_pc = 32'h100; exc_badaddr = 32'hdead;
        tick();
        idle_inputs();
        checks++;
        if ({flush, stall, redirect} !== 3'b110) begin
            errors++; $display("FAIL ov_flush got %b exp 110", {flush, stall, redirect});
        end
        checks++;
        if (epc !== 32'h100 || cause[6:2] !== 5'd12 || status[1] !== 1'b1) begin
            errors++; $display("FAIL ov_regs got epc=%h code=%0d exl=%b exp 100 12 1", epc, cause[6:2], status[1]);
        end
        checks++;
        if (badvaddr !== 32'd0) begin
            errors++; $display("FAIL ov_badvaddr got %h exp 0", badvaddr);
        end
        tick();
        checks++;
        if ({flush, stall, redirect} !== 3'b011 || redirect_pc !== 32'h80) begin
            errors++; $display("FAIL ov_redirect got %b pc=%h exp 011 80", {flush, stall, redirect}, redirect_pc);
        end
        tick();
        checks++;
        if ({flush, stall, redirect} !== 3'b000) begin
            errors++; $display("FAIL ov_run got %b exp 000", {flush, stall, redirect});
        end
    endtask

    task automatic test_adel_eret();
        sr_we = 1'b1; sr_wdata = 32'd0;
        tick();
        idle_inputs();
        checks++;
        if (status !== 32'd0) begin
            errors++; $display("FAIL sr_clear got %h exp 0", status);
        end
        exc_valid = 1'b1; exc = F_ADEL | F_OV; exc_pc = 32'h300; exc_badaddr = 32'h1003;
        tick();
        idle_inputs();
        checks++;
        if (cause[6:2] !== 5'd4 || badvaddr !== 32'h1003 || epc !== 32'h300) begin
            errors++; $display("FAIL adel_regs got code=%0d bva=%h epc=%h exp 4 1003 300", cause[6:2], badvaddr, epc);
        end
        tick();
        checks++;
        if (redirect !== 1'b1 || redirect_pc !== 32'h80) begin
            errors++; $display("FAIL adel_redirect got %b pc=%h exp 1 80", redirect, redirect_pc);
        end
        tick();
        exc_valid = 1'b1; eret = 1'b1;
        tick();
        idle_inputs();
        checks++;
        if (flush !== 1'b1 || status[1] !== 1'b0) begin
            errors++; $display("FAIL eret_flush got flush=%b exl=%b exp 1 0", flush, status[1]);
        end
        tick();
        checks++;
        if (redirect !== 1'b1 || redirect_pc !== 32'h300) begin
            errors++; $display("FAIL eret_redirect got %b pc=%h exp 1 300", redirect, redirect_pc);
        end
        tick();
    endtask

    task automatic test_timer_int();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        cyc = 0;
        sr_we = 1'b1; sr_wdata = 32'h0000_1F01;
        tick();
        idle_inputs();
        checks++;
        if (status !== 32'h0000_1F01) begin
            errors++; $display("FAIL sr_write got %h exp 00001f01", status);
        end
        while (cyc < 99) tick();
        checks++;
        if (cause[8] !== 1'b0) begin
            errors++; $display("FAIL timer_early got %b exp 0", cause[8]);
        end
        tick();
        checks++;
        if (cause[8] !== 1'b1 || flush !== 1'b0) begin
            errors++; $display("FAIL timer_pend got ip=%b flush=%b exp 1 0", cause[8], flush);
        end
        exc_valid = 1'b1; exc_pc = 32'h400;
        tick();
        idle_inputs();
        checks++;
        if (flush !== 1'b1 || cause[6:2] !== 5'd0 || epc !== 32'h400 || status[1] !== 1'b1) begin
            errors++; $display("FAIL int_take got flush=%b code=%0d epc=%h exl=%b exp 1 0 400 1", flush, cause[6:2], epc, status[1]);
        end
        tick();
        checks++;
        if (redirect !== 1'b1 || redirect_pc !== 32'h80) begin
            errors++; $display("FAIL int_redirect got %b pc=%h exp 1 80", redirect, redirect_pc);
        end
        tick();
        timer_ack = 1'b1;
        tick();
        timer_ack = 1'b0;
        checks++;
        if (cause[8] !== 1'b0) begin
            errors++; $display("FAIL timer_ack got %b exp 0", cause[8]);
        end
        while (cyc < 199) tick();
        timer_ack = 1'b1;
        tick();
        checks++;
        if (cause[8] !== 1'b1) begin
            errors++; $display("FAIL timer_ack_expiry got %b exp 1", cause[8]);
        end
        tick();
        timer_ack = 1'b0;
        checks++;
        if (cause[8] !== 1'b0) begin
            errors++; $display("FAIL timer_ack2 got %b exp 0", cause[8]);
        end
    endtask

    task automatic test_nested();
        irq = 4'b0001;
        exc_valid = 1'b1; exc_pc = 32'h500;
        tick();
        idle_inputs();
        checks++;
        if (flush !== 1'b0 || cause[9] !== 1'b1) begin
            errors++; $display("FAIL irq_masked got flush=%b ip=%b exp 0 1", flush, cause[9]);
        end
        exc_valid = 1'b1; exc = F_SYS; exc_pc = 32'h200;
        tick();
        idle_inputs();
        checks++;
        if (flush !== 1'b1 || epc !== 32'h400 || cause[6:2] !== 5'd8) begin
            errors++; $display("FAIL nested_take got flush=%b epc=%h code=%0d exp 1 400 8", flush, epc, cause[6:2]);
        end
        tick();
        checks++;
        if (redirect !== 1'b1 || redirect_pc !== 32'h80) begin
            errors++; $display("FAIL nested_redirect got %b pc=%h exp 1 80", redirect, redirect_pc);
        end
        tick();
        irq = 4'b0000;
    endtask

    task automatic test_rst_flush();
        exc_valid = 1'b1; exc = F_OV; exc_pc = 32'h600;
        tick();
        idle_inputs();
        checks++;
        if (flush !== 1'b1) begin
            errors++; $display("FAIL rstf_flush got %b exp 1", flush);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if ({flush, stall, redirect} !== 3'b000 || epc !== 32'd0 || status !== 32'd0) begin
            errors++; $display("FAIL rstf_clear got %b epc=%h st=%h exp 000 0 0", {flush, stall, redirect}, epc, status);
        end
        tick();
        checks++;
        if (redirect !== 1'b0 || stall !== 1'b0) begin
            errors++; $display("FAIL rstf_noredir got redirect=%b stall=%b exp 0 0", redirect, stall);
        end
    endtask

    initial begin
        rst       = 1'b1;
        irq       = 4'd0;
        timer_ack = 1'b0;
        idle_inputs();
        test_reset();
        test_ov();
        test_adel_eret();
        test_timer_int();
        test_nested();
        test_rst_flush();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
